// File: rtl/cmp_ext_pkg.sv
// Shared types and widths for the compare / immediate-extend unit.
package cmp_ext_pkg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IMM_W-1:0]  imm_t;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_mode_t;

endpackage

// File: rtl/cmp_ext_unit_imm_extender.sv
// Combinational immediate extender: widens imm to WIDTH bits, filling the
// upper bits with either the immediate's sign bit or zeros.
module imm_extender
  import cmp_ext_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int IMM_WIDTH = IMM_W
) (
  input  logic [IMM_WIDTH-1:0] imm,
  input  ext_mode_t            mode,
  output logic [WIDTH-1:0]     ext
);

  generate
    if (WIDTH > IMM_WIDTH) begin : g_widen
      logic fill;
      assign fill = (mode == EXT_SIGN) & imm[IMM_WIDTH-1];
      assign ext  = {{(WIDTH-IMM_WIDTH){fill}}, imm};
    end else begin : g_same
      // Equal widths leave nothing to fill; mode has no effect.
      assign ext = imm;
    end
  endgenerate

endmodule

// File: rtl/cmp_ext_unit.sv
// Registered 32-bit equality compare (beq/bne) plus I-type immediate extend.
// Optional zero-extension select is enabled by defining CMP_EXT_ZERO_EXT_EN.
module cmp_ext_unit
  import cmp_ext_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int IMM_WIDTH = IMM_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [IMM_WIDTH-1:0] imm,
`ifdef CMP_EXT_ZERO_EXT_EN
  input  logic                 ext_zero,
`endif
  output logic                 out_valid,
  output logic                 eq,
  output logic                 ne,
  output logic [WIDTH-1:0]     ext
);

  localparam int STAGES = 1;

  logic [STAGES:0]  vld_pipe;
  ext_mode_t        mode;
  logic [WIDTH-1:0] ext_d;
  logic             eq_d;
  logic             eq_q, ne_q;
  logic [WIDTH-1:0] ext_q;

`ifdef CMP_EXT_ZERO_EXT_EN
  assign mode = ext_zero ? EXT_ZERO : EXT_SIGN;
`else
  assign mode = EXT_SIGN;
`endif

  imm_extender #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_ext (
    .imm  (imm),
    .mode (mode),
    .ext  (ext_d)
  );

  assign eq_d        = (a0 == a1);
  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      eq_q               <= 1'b0;
      ne_q               <= 1'b0;
      ext_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      eq_q               <= in_valid & eq_d;
      ne_q               <= in_valid & ~eq_d;
      // ext only moves on a valid op so idle cycles don't toggle downstream.
      if (in_valid) ext_q <= ext_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign eq        = eq_q;
  assign ne        = ne_q;
  assign ext       = ext_q;

endmodule

// File: tb/tb_cmp_ext_unit.sv
// Self-checking bench for cmp_ext_unit: directed cases plus random traffic
// checked against a small spec-level reference model.
module tb_cmp_ext_unit;
  import cmp_ext_pkg::*;

  logic  clk = 1'b0;
  logic  reset, in_valid, ext_zero;
  data_t a0, a1;
  imm_t  imm;
  logic  out_valid, eq, ne;
  data_t ext;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the outputs must show after the last edge.
  logic  m_vld, m_eq, m_ne;
  data_t m_ext;

  always #5 clk = ~clk;

  cmp_ext_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a0        (a0),
    .a1        (a1),
    .imm       (imm),
`ifdef CMP_EXT_ZERO_EXT_EN
    .ext_zero  (ext_zero),
`endif
    .out_valid (out_valid),
    .eq        (eq),
    .ne        (ne),
    .ext       (ext)
  );

  function automatic data_t widen(input imm_t i, input logic zero);
    int unsigned v;
    v = i;
`ifdef CMP_EXT_ZERO_EXT_EN
    if (!zero && v >= 32768) v = v + 32'hFFFF_0000;
`else
    if (v >= 32768) v = v + 32'hFFFF_0000;
`endif
    return data_t'(v);
  endfunction

  // Drive one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input logic r, input logic v, input data_t x, input data_t y,
                      input imm_t i, input logic z);
    @(negedge clk);
    reset = r; in_valid = v; a0 = x; a1 = y; imm = i; ext_zero = z;
    @(posedge clk);
    if (r) begin
      m_vld = 0; m_eq = 0; m_ne = 0; m_ext = '0;
    end else if (v) begin
      m_vld = 1; m_eq = (x == y); m_ne = (x != y); m_ext = widen(i, z);
    end else begin
      m_vld = 0; m_eq = 0; m_ne = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1, 1, '0, '0, 16'hFFFF, 0);
      checks++;
      if (out_valid !== 1'b0 || eq !== 1'b0 || ne !== 1'b0 || ext !== 32'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: got v=%b eq=%b ne=%b ext=%h want 0 0 0 00000000",
                 k, out_valid, eq, ne, ext);
      end
    end
  endtask

  task automatic test_equal();
    data_t vals [2] = '{32'h0, 32'hFFFF_FFFF};
    for (int k = 0; k < 2; k++) begin
      step(0, 1, vals[k], vals[k], 16'h0001, 0);
      checks++;
      if (out_valid !== 1'b1 || eq !== 1'b1 || ne !== 1'b0) begin
        errors++;
        $display("FAIL equal %h: got v=%b eq=%b ne=%b want 1 1 0", vals[k], out_valid, eq, ne);
      end
    end
  endtask

  task automatic test_unequal();
    data_t xs [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    for (int k = 0; k < 3; k++) begin
      step(0, 1, xs[k], 32'h0, 16'h0002, 0);
      checks++;
      if (out_valid !== 1'b1 || eq !== 1'b0 || ne !== 1'b1) begin
        errors++;
        $display("FAIL unequal %h: got v=%b eq=%b ne=%b want 1 0 1", xs[k], out_valid, eq, ne);
      end
    end
  endtask

  task automatic test_sign_ext();
    imm_t  is [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    data_t es [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_7FFF, 32'hFFFF_8000};
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 32'h5, 32'h5, is[k], 0);
      checks++;
      if (ext !== es[k]) begin
        errors++;
        $display("FAIL sign_ext imm=%h: got %h want %h", is[k], ext, es[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    data_t last;
    for (int k = 0; k < 4; k++) begin
      data_t x = $urandom;
      data_t y = (k % 2 == 0) ? x : x ^ (32'h1 << k);
      imm_t  i = imm_t'($urandom);
      step(0, 1, x, y, i, 0);
      checks++;
      if (out_valid !== 1'b1 || eq !== (k % 2 == 0) || ne !== (k % 2 != 0) || ext !== m_ext) begin
        errors++;
        $display("FAIL b2b cyc%0d: got v=%b eq=%b ne=%b ext=%h want 1 %b %b %h",
                 k, out_valid, eq, ne, ext, k % 2 == 0, k % 2 != 0, m_ext);
      end
    end
    last = m_ext;
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 32'h7, 32'h7, imm_t'($urandom), 0);
      checks++;
      if (out_valid !== 1'b0 || eq !== 1'b0 || ne !== 1'b0 || ext !== last) begin
        errors++;
        $display("FAIL hold cyc%0d: got v=%b eq=%b ne=%b ext=%h want 0 0 0 %h",
                 k, out_valid, eq, ne, ext, last);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      logic  r = ($urandom_range(0, 19) == 0);
      logic  v = ($urandom_range(0, 3) != 0);
      data_t x = $urandom;
      data_t y;
      int    sel = $urandom_range(0, 2);
      if (sel == 0) y = x;
      else if (sel == 1) y = x ^ (32'h1 << $urandom_range(0, 31));
      else y = $urandom;
      step(r, v, x, y, imm_t'($urandom), logic'($urandom_range(0, 1)));
      checks++;
      if (out_valid !== m_vld || eq !== m_eq || ne !== m_ne || ext !== m_ext) begin
        errors++;
        $display("FAIL random cyc%0d: got v=%b eq=%b ne=%b ext=%h want %b %b %b %h",
                 k, out_valid, eq, ne, ext, m_vld, m_eq, m_ne, m_ext);
      end
    end
  endtask

`ifdef CMP_EXT_ZERO_EXT_EN
  task automatic test_zero_ext();
    logic  zs [2] = '{1'b1, 1'b0};
    data_t es [2] = '{32'h0000_8000, 32'hFFFF_8000};
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 32'h0, 32'h0, 16'h8000, zs[k]);
      checks++;
      if (ext !== es[k]) begin
        errors++;
        $display("FAIL zero_ext z=%b: got %h want %h", zs[k], ext, es[k]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1; in_valid = 0; a0 = '0; a1 = '0; imm = '0; ext_zero = 0;
    m_vld = 0; m_eq = 0; m_ne = 0; m_ext = '0;
    test_reset();
    test_equal();
    test_unequal();
    test_sign_ext();
    test_back_to_back();
`ifdef CMP_EXT_ZERO_EXT_EN
    test_zero_ext();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
